// File: rtl/risc_v_pipeline_pkg.sv
// risc_v_pipeline_pkg: shared fetch-stage types and constants. rev 1.0
`default_nettype none

package risc_v_pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/if_hold_reg.sv
// if_hold_reg: holds the presented instruction while decode is stalled. rev 1.0
`default_nettype none

module if_hold_reg
  import risc_v_pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output logic [31:0] pc_q,
  output logic [31:0] instr_q,
  output logic        valid_q
);

  // Clear wins over capture so a redirect always empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (clear) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (capture) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with stall buffering and redirect. rev 1.0
`default_nettype none

module fetch_unit
  import risc_v_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_sel_i,
  input  logic [31:0] pc_target_i,
  input  logic        stall_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o,
  output logic        pc_misalign_o
);

  fetch_state_e state, state_next;

  logic [31:0] pc, pc_next, req_pc;
  logic        req_q, fetch, misalign_q;
  logic        capture, hold_clear;
  logic [31:0] hold_pc, hold_instr;
  logic        hold_valid;
  logic [31:0] run_instr;

  // Response for last cycle's request, as seen in RUN.
  assign run_instr = req_q ? imem_rdata_i : NOP_INSTR;

  if_hold_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .clear   (hold_clear),
    .pc_d    (req_pc),
    .instr_d (run_instr),
    .valid_d (req_q),
    .pc_q    (hold_pc),
    .instr_q (hold_instr),
    .valid_q (hold_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    capture    = 1'b0;
    hold_clear = 1'b0;
    pc_next    = pc;
    if_pc_o    = 32'h0;
    if_instr_o = NOP_INSTR;
    if_valid_o = 1'b0;
    if (pc_sel_i) begin
      state_next = REDIRECT;
      hold_clear = 1'b1;
      pc_next    = {pc_target_i[31:2], 2'b00};
    end else begin
      case (state)
        RUN: begin
          if_pc_o    = req_pc;
          if_instr_o = run_instr;
          if_valid_o = req_q;
          if (stall_i) begin
            capture    = 1'b1;
            state_next = STALL;
          end else begin
            fetch = 1'b1;
          end
        end
        STALL: begin
          if_pc_o    = hold_pc;
          if_instr_o = hold_instr;
          if_valid_o = hold_valid;
          if (!stall_i) begin
            fetch      = 1'b1;
            state_next = RUN;
          end
        end
        REDIRECT: begin
          // Bubble slot; the target fetch goes out regardless of stall.
          fetch      = 1'b1;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
      if (fetch) pc_next = pc + 32'd4;
    end
  end

  assign imem_addr_o   = pc;
  assign imem_req_o    = fetch & rst_n;
  assign pc_misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      req_pc     <= 32'h0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc         <= pc_next;
      req_pc     <= pc;
      req_q      <= fetch;
      misalign_q <= pc_sel_i & (pc_target_i[1:0] != 2'b00);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a cycle reference model. rev 1.0
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;
  logic        imem_req, if_valid, misalign;

  logic [31:0] w_addr, w_pc, w_instr;
  logic        w_req, w_valid, w_mis;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel_i      (pc_sel),
    .pc_target_i   (pc_target),
    .stall_i       (stall),
    .imem_addr_o   (imem_addr),
    .imem_req_o    (imem_req),
    .imem_rdata_i  (imem_rdata),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_valid_o    (if_valid),
    .pc_misalign_o (misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel_i      (1'b0),
    .pc_target_i   (32'h0),
    .stall_i       (1'b0),
    .imem_addr_o   (w_addr),
    .imem_req_o    (w_req),
    .imem_rdata_i  (32'h0),
    .if_pc_o       (w_pc),
    .if_instr_o    (w_instr),
    .if_valid_o    (w_valid),
    .pc_misalign_o (w_mis)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? mem(imem_addr) : 32'hBAD0_BAD0;

  // Reference model: next fetch address, in-flight request, hold buffer, redirect bubble.
  logic [31:0] m_pc, m_infl_addr, h_pc, h_instr;
  bit          m_redir, m_held, m_infl, h_valid, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_redir = 0; m_held = 0; m_infl = 0; m_mis = 0;
    m_infl_addr = 32'h0; h_pc = 32'h0; h_instr = NOP; h_valid = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit sel, input logic [31:0] tgt, input bit stl);
    logic [31:0] e_pc, e_instr;
    bit          e_valid, e_req;
    pc_sel = sel; pc_target = tgt; stall = stl;
    @(negedge clk);
    e_pc = 32'h0; e_instr = NOP; e_valid = 0; e_req = 0;
    if (!sel) begin
      if (m_redir) e_req = 1;
      else begin
        e_req = !stl;
        if (m_held) begin
          e_pc = h_pc; e_instr = h_instr; e_valid = h_valid;
        end else if (m_infl) begin
          e_pc = m_infl_addr; e_instr = mem(m_infl_addr); e_valid = 1;
        end
      end
    end
    check("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
    check("if_instr", if_instr, e_instr);
    if (e_valid) check("if_pc", if_pc, e_pc);
    check("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("misalign", {31'h0, misalign}, {31'h0, m_mis});
    @(posedge clk);
    m_mis = sel && (tgt[1:0] != 2'b00);
    if (sel) begin
      m_pc = {tgt[31:2], 2'b00}; m_held = 0; m_infl = 0; m_redir = 1;
    end else if (m_redir) begin
      m_redir = 0; m_infl = 1; m_infl_addr = m_pc; m_pc = m_pc + 32'd4;
    end else if (stl) begin
      if (!m_held) begin
        m_held = 1; h_pc = e_pc; h_instr = e_instr; h_valid = e_valid;
      end
      m_infl = 0;
    end else begin
      m_held = 0; m_infl = 1; m_infl_addr = m_pc; m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_instr", if_instr, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_mis", {31'h0, misalign}, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1 rst_n = 1'b1;

    // Wrap instance: fetch at 0xFFFF_FFFC, then 0x0.
    @(negedge clk);
    check("wrap_req0", {31'h0, w_req}, 32'h1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'h0, w_valid}, 32'h0);
    check("wrap_instr0", w_instr, NOP);
    @(negedge clk);
    check("wrap_addr1", w_addr, 32'h0000_0000);
    check("wrap_valid1", {31'h0, w_valid}, 32'h1);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap_instr1", w_instr, 32'h0);
    check("wrap_mis", {31'h0, w_mis}, 32'h0);

    // Fresh reset for the main sequence.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    // Sequential fetch, then a 3-cycle stall while 0x8 is presented.
    repeat (3) step(0, 32'h0, 0);
    check("present_8", if_pc, 32'h8);
    repeat (3) step(0, 32'h0, 1);
    repeat (2) step(0, 32'h0, 0);

    // Redirect to 0x100: two bubbles then target.
    step(1, 32'h100, 0);
    repeat (3) step(0, 32'h0, 0);

    // Redirect together with stall wins; stall held across the bubble.
    step(0, 32'h0, 1);
    step(1, 32'h40, 1);
    step(0, 32'h0, 1);
    repeat (2) step(0, 32'h0, 0);

    // Misaligned target.
    step(1, 32'h102, 0);
    step(0, 32'h0, 0);
    check("misalign_addr", imem_addr, 32'h104);
    repeat (2) step(0, 32'h0, 0);

    // Back-to-back redirects restart the bubble.
    step(1, 32'h200, 0);
    step(1, 32'h303, 0);
    repeat (3) step(0, 32'h0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_0FFF);
      step(($urandom % 8) == 0, t, ($urandom % 4) == 0);
    end

    // Reset in the middle of a stall drops everything at once.
    repeat (2) step(0, 32'h0, 0);
    repeat (2) step(0, 32'h0, 1);
    rst_n = 1'b0;
    stall = 1'b0;
    #1;
    check("midrst_valid", {31'h0, if_valid}, 32'h0);
    check("midrst_instr", if_instr, NOP);
    check("midrst_pc", if_pc, 32'h0);
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_mis", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    repeat (4) step(0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
